// File: rtl/ds_emu_pkg.sv
// Shared types and arithmetic helpers for the multi-channel delta-sigma emulator.
package ds_emu_pkg;

  typedef enum logic {
    DS_ORDER1 = 1'b0,
    DS_ORDER2 = 1'b1
  } ds_mode_e;

  // Integrator width for a given level width: three bits of headroom over the level.
  function automatic int unsigned acc_w(input int unsigned in_w);
    return in_w + 3;
  endfunction

  // Adds two already sign-extended operands and clamps the result to the signed
  // range of a w-bit integrator; ovf reports whether the clamp engaged.
  function automatic longint sat_add(input longint a, input longint b,
                                     input int unsigned w, output logic ovf);
    longint hi;
    longint lo;
    longint s;
    hi  = (longint'(1) <<< (w - 1)) - 1;
    lo  = -hi - 1;
    s   = a + b;
    ovf = 1'b0;
    if (s > hi) begin
      s   = hi;
      ovf = 1'b1;
    end else if (s < lo) begin
      s   = lo;
      ovf = 1'b1;
    end
    return s;
  endfunction

endpackage

// File: rtl/ds_modulator_ch.sv
// One delta-sigma channel: first/second integrator, output bit and sticky overflow flag.
module ds_modulator_ch
  import ds_emu_pkg::*;
#(
  parameter int unsigned IN_W  = 12,
  parameter int unsigned ACC_W = acc_w(IN_W)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick,
  input  logic                   clr_i2,
  input  logic                   clr_ovf,
  input  logic signed [IN_W-1:0] x,
  input  ds_mode_e               mode,
  output logic                   drive,
  output logic                   ovf
);

  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic signed [SUM_W-1:0] FS = SUM_W'(longint'(1) <<< (IN_W - 1));

  logic signed [ACC_W-1:0] i1;
  logic signed [ACC_W-1:0] i2;
  logic signed [ACC_W-1:0] i1_nxt;
  logic signed [ACC_W-1:0] i2_nxt;
  logic signed [SUM_W-1:0] x_ext;
  logic signed [SUM_W-1:0] fb;
  logic signed [SUM_W-1:0] i1_ext;
  logic signed [SUM_W-1:0] i2_ext;
  logic signed [SUM_W-1:0] i1n_ext;
  logic                    ovf1;
  logic                    ovf2;
  logic                    y;
  logic                    sat_hit;

  // Next integrator values and output bit for a tick, using current state.
  always_comb begin
    x_ext   = {{(SUM_W - IN_W){x[IN_W-1]}}, x};
    i1_ext  = {i1[ACC_W-1], i1};
    i2_ext  = {i2[ACC_W-1], i2};
    fb      = drive ? FS : -FS;
    ovf1    = 1'b0;
    ovf2    = 1'b0;
    i1_nxt  = ACC_W'(sat_add(longint'(i1_ext) + longint'(x_ext), -longint'(fb), ACC_W, ovf1));
    i1n_ext = {i1_nxt[ACC_W-1], i1_nxt};
    i2_nxt  = ACC_W'(sat_add(longint'(i2_ext) + longint'(i1n_ext), -longint'(fb), ACC_W, ovf2));
    if (mode == DS_ORDER2) begin
      y       = ~i2_nxt[ACC_W-1];
      sat_hit = ovf1 | ovf2;
    end else begin
      y       = ~i1_nxt[ACC_W-1];
      sat_hit = ovf1;
    end
  end

  // Integrator and output-bit state, advanced only on modulator ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1    <= '0;
      i2    <= '0;
      drive <= 1'b0;
    end else begin
      if (tick) begin
        i1    <= i1_nxt;
        drive <= y;
        if (mode == DS_ORDER2) begin
          i2 <= i2_nxt;
        end
      end
      // A mode switch restarts i2 even when a tick (still in the old mode) shares the edge.
      if (clr_i2) begin
        i2 <= '0;
      end
    end
  end

  // Sticky saturation flag; a saturation on the clearing edge keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (tick && sat_hit) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/ds_adc_emulator_mc.sv
// Multi-channel delta-sigma ADC emulator: rate divider, shadow level/mode registers,
// output strobe, and N_CH modulator channels.
module ds_adc_emulator_mc
  import ds_emu_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned IN_W  = 12,
  parameter int unsigned DIV   = 4,
  parameter int unsigned ACC_W = acc_w(IN_W)
) (
  input  logic                   CLK,
  input  logic                   RST_B,
  input  logic                   EN,
  input  logic                   LOAD,
  input  logic [N_CH*IN_W-1:0]   LEVEL,
  input  logic                   MODE,
  input  logic                   CLR_OVF,
  output logic [N_CH-1:0]        DRIVE,
  output logic                   STROBE,
  output logic [N_CH-1:0]        OVF
);

  localparam int unsigned    CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0]      cnt;
  logic                  tick;
  logic [N_CH*IN_W-1:0]  level_sh;
  ds_mode_e              mode_sh;
  ds_mode_e              mode_in;
  logic                  clr_i2;

  // Tick qualification and detection of a mode change being loaded.
  always_comb begin
    tick    = EN && (cnt == CNT_LAST);
    mode_in = ds_mode_e'(MODE);
    clr_i2  = LOAD && (mode_in != mode_sh);
  end

  // Rate divider: counts enabled cycles, wrapping after the tick cycle.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      cnt <= '0;
    end else if (EN) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

  // Shadow registers; channels read the pre-edge values, so a coincident tick uses old settings.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      level_sh <= '0;
      mode_sh  <= DS_ORDER1;
    end else if (LOAD) begin
      level_sh <= LEVEL;
      mode_sh  <= mode_in;
    end
  end

  // Strobe marks the edge on which DRIVE was just updated.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      STROBE <= 1'b0;
    end else begin
      STROBE <= tick;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    ds_modulator_ch #(
      .IN_W  (IN_W),
      .ACC_W (ACC_W)
    ) u_ch (
      .clk     (CLK),
      .rst_n   (RST_B),
      .tick    (tick),
      .clr_i2  (clr_i2),
      .clr_ovf (CLR_OVF),
      .x       (level_sh[k*IN_W +: IN_W]),
      .mode    (mode_sh),
      .drive   (DRIVE[k]),
      .ovf     (OVF[k])
    );
  end

endmodule
